imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Two-port arbiter and sequencer for the instruction memory. It shares the single memory port between the instruction-fetch requester (read-only) and the loader/debug requester (read/write). It enforces a boot phase in which only the loader may access memory, then arbitrates both requesters. It also tracks the owner of each outstanding access so that the one-cycle-delayed response reaches the correct requester. It sits between the fetch stage / program loader and the instruction memory wrapper.

## Interface
- `ADDR_W`, default 8: memory word address width.
- `DATA_W`, default 32: data width.
- `STARVE_LIMIT`, default 4: maximum number of consecutive denied fetch cycles in fixed-priority mode; range 1..15.

Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `boot_done`  in  1  loader finished; ends the BOOT phase.
- `f_req`  in  1  fetch read request.
- `f_addr`  in  ADDR_W  fetch address.
- `f_gnt`  out  1  fetch request accepted this cycle.
- `f_rvalid`  out  1  fetch response valid.
- `f_rdata`  out  DATA_W  fetch read data.
- `l_req`  in  1  loader request.
- `l_we_re`  in  1  loader operation: 1 = write, 0 = read.
- `l_mask`  in  4  loader byte-write mask.
- `l_addr`  in  ADDR_W  loader address.
- `l_wdata`  in  DATA_W  loader write data.
- `l_gnt`  out  1  loader request accepted this cycle.
- `l_rvalid`  out  1  loader response (read data or write acknowledge).
- `l_rdata`  out  DATA_W  loader read data.
- `mem_request`, `mem_we_re`, `mem_mask[3:0]`, `mem_address[ADDR_W]`, `mem_data_in[DATA_W]`  out  memory command.
- `mem_valid`  in  1  memory response; high exactly one cycle after `mem_request`.
- `mem_data_out`  in  DATA_W  memory read data.
- `boot_mode`  out  1  high while in the BOOT state.

## Operation
- **State machine:**
  - BOOT (reset state): only the loader is granted; `f_gnt` is held at 0.
  - BOOT → RUN when `boot_done` = 1 is sampled at a rising edge.
  - RUN is sticky until reset; `boot_done` is ignored in RUN.
- **Grant:** combinational, in the same cycle as the request.
  - A requester holds `req` and its command stable until it sees `gnt`.
  - At most one grant per cycle.
  - `mem_request` = `f_gnt` | `l_gnt`.
- **Command mux:**
  - Fetch grant: `mem_we_re` = 0, `mem_mask` = 4'b1111, `mem_address` = `f_addr`, `mem_data_in` = 0.
  - Loader grant: loader fields pass through.
  - No grant: all command outputs are 0.
- **Owner tracking:**
  - The `owner` register captures the granted port (F/L) and an `outstanding` bit every cycle.
  - `f_rvalid` = `mem_valid` & `outstanding` & owner==F.
  - `l_rvalid` = `mem_valid` & `outstanding` & owner==L.
  - `f_rdata` = `l_rdata` = `mem_data_out`.
  - Back-to-back grants to alternating ports are legal; each response is routed by the owner of the previous cycle.
- **Default arbitration (fixed priority, RUN):**
  - The loader wins every conflict.
  - `starve_cnt` (4 bits) increments on each cycle with `f_req` high and `f_gnt` low.
  - When `starve_cnt` == `STARVE_LIMIT`, fetch wins that cycle regardless of `l_req`.
  - `starve_cnt` clears on `f_gnt` or when `f_req` is low.
- **Simultaneous events:**
  - `boot_done` rising with both requests pending: the loader is granted in that cycle; arbitration applies from the next cycle.
  - `mem_valid` high with `outstanding` = 0 (spurious): both rvalids stay 0.

## Timing
- Grant latency is 0 cycles; response latency is 1 cycle after grant, and every grant produces exactly one rvalid.
- Sustained throughput is one access per cycle.
- Reset values:
  - `f_gnt`, `l_gnt`, `f_rvalid`, `l_rvalid`, and all `mem_*` outputs are 0.
  - `boot_mode` is 1.
  - `starve_cnt`, `owner`, `outstanding`, and `last_gnt` are 0.
- Reset asserted mid-operation: any outstanding response is dropped (no rvalid after release) and the block returns to BOOT.

## Configuration
- `IMEM_ARB_RR_EN` defined: RUN-state conflicts are resolved round-robin.
  - A `last_gnt` register is updated on every grant.
  - On conflict, the port not granted last wins; `last_gnt` resets to L, so fetch wins the first conflict.
  - `starve_cnt` and `STARVE_LIMIT` are unused.
- Not defined: fixed loader priority with the starvation counter, as described above. BOOT behaviour is identical in both builds.

## Test plan
- **Boot lockout:** reset, `f_req` = 1 and `l_req` = 1 (write, `l_addr` = 8'h10, `l_wdata` = 32'hDEADBEEF, mask 4'hF) → `f_gnt` = 0 and `l_gnt` = 1. The next cycle gives `l_rvalid` = 1, and `boot_mode` stays 1.
- **Boot exit:** `boot_done` pulse → `boot_mode` = 0 next cycle. Then `f_req` with `f_addr` = 8'h10 → `f_gnt` = 1, and one cycle later `f_rvalid` = 1 with `f_rdata` = 32'hDEADBEEF.
- **Starvation (default build, `STARVE_LIMIT` = 4):** both requests held continuously → 4 loader grants, then 1 fetch grant, repeating.
- **Round-robin (`IMEM_ARB_RR_EN`):** both requests held → grants alternate F, L, F, L.
- **Back-to-back routing:** grant F at cycle n and L at cycle n+1 → `f_rvalid` only at n+1 and `l_rvalid` only at n+2, with no cross-delivery.
- **Reset mid-access:** `rst` low in the cycle after a grant → no rvalid, `boot_mode` = 1, and all `mem_*` outputs are 0.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: bus bundle between fetch stage, program loader, arbiter and instruction memory.
// Ports: fetch (f_*), loader (l_*) and memory (mem_*) signals.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface imem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_gnt;
   logic              f_rvalid;
   logic [DATA_W-1:0] f_rdata;
   logic              l_req;
   logic              l_we_re;
   logic [3:0]        l_mask;
   logic [ADDR_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              l_gnt;
   logic              l_rvalid;
   logic [DATA_W-1:0] l_rdata;
   logic              mem_request;
   logic              mem_we_re;
   logic [3:0]        mem_mask;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_valid;
   logic [DATA_W-1:0] mem_data_out;
   modport slave (
      input  f_req, f_addr, l_req, l_we_re, l_mask, l_addr, l_wdata, mem_valid, mem_data_out,
      output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
             mem_request, mem_we_re, mem_mask, mem_address, mem_data_in
   );
   modport master (
      output f_req, f_addr, l_req, l_we_re, l_mask, l_addr, l_wdata, mem_valid, mem_data_out,
      input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
             mem_request, mem_we_re, mem_mask, mem_address, mem_data_in
   );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction-memory port between fetch (read-only) and loader (read/write).
// Ports: clk, rst_n (async active-low), boot_done in, boot_mode out, bus (imem_arbiter_if.slave).
// Optional macro IMEM_ARB_RR_EN: round-robin conflict resolution in RUN instead of
// fixed loader priority with a fetch starvation counter.
module imem_arbiter #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           boot_done,
   output logic           boot_mode,
   imem_arbiter_if.slave  bus
);
   typedef enum logic {BOOT, RUN} state_t;
   typedef enum logic {PORT_L = 1'b0, PORT_F = 1'b1} port_t;
   state_t state;
   port_t  owner;
   logic   outstanding;
   logic   f_win;
   logic   f_gnt;
   logic   l_gnt;
`ifdef IMEM_ARB_RR_EN
   port_t  last_gnt;
   always_comb f_win = bus.f_req & (!bus.l_req | last_gnt == PORT_L);
`else
   logic [3:0] starve_cnt;
   always_comb f_win = bus.f_req & (!bus.l_req | starve_cnt == 4'(STARVE_LIMIT));
`endif
   // Grants are gated by reset so every memory command output reads 0 while held in reset.
   always_comb begin
      f_gnt           = rst_n & (state == RUN) & f_win;
      l_gnt           = rst_n & bus.l_req & !f_gnt;
      bus.f_gnt       = f_gnt;
      bus.l_gnt       = l_gnt;
      bus.mem_request = f_gnt | l_gnt;
      bus.mem_we_re   = l_gnt & bus.l_we_re;
      bus.mem_mask    = l_gnt ? bus.l_mask : f_gnt ? 4'hF : 4'h0;
      bus.mem_address = l_gnt ? bus.l_addr : f_gnt ? bus.f_addr : {ADDR_W{1'b0}};
      bus.mem_data_in = l_gnt ? bus.l_wdata : {DATA_W{1'b0}};
      bus.f_rvalid    = bus.mem_valid & outstanding & (owner == PORT_F);
      bus.l_rvalid    = bus.mem_valid & outstanding & (owner == PORT_L);
      bus.f_rdata     = bus.mem_data_out;
      bus.l_rdata     = bus.mem_data_out;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT;
         boot_mode   <= 1'b1;
         owner       <= PORT_L;
         outstanding <= 1'b0;
`ifdef IMEM_ARB_RR_EN
         last_gnt    <= PORT_L;
`else
         starve_cnt  <= 4'd0;
`endif
      end else begin
         if (state == BOOT && boot_done) begin
            state     <= RUN;
            boot_mode <= 1'b0;
         end
         owner       <= f_gnt ? PORT_F : PORT_L;
         outstanding <= f_gnt | l_gnt;
`ifdef IMEM_ARB_RR_EN
         last_gnt    <= f_gnt ? PORT_F : l_gnt ? PORT_L : last_gnt;
`else
         // Counting only in RUN keeps the boot lockout from pre-loading the starvation count.
         starve_cnt  <= (state == RUN && bus.f_req && !f_gnt) ? starve_cnt + 4'd1 : 4'd0;
`endif
      end
   end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed table-driven bench for imem_arbiter with a one-cycle memory model.
module tb_imem_arbiter;
   logic clk;
   logic rst_n;
   logic boot_done;
   logic boot_mode;
   int   checks;
   int   errors;
   logic [31:0] mem [256];
   imem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();
   imem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .boot_done(boot_done), .boot_mode(boot_mode), .bus(bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (!rst_n) begin
         bus.mem_valid    <= 1'b0;
         bus.mem_data_out <= 32'h0;
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      end else begin
         bus.mem_valid <= bus.mem_request;
         if (bus.mem_request) begin
            bus.mem_data_out <= mem[bus.mem_address];
            if (bus.mem_we_re)
               for (int b = 0; b < 4; b++)
                  if (bus.mem_mask[b]) mem[bus.mem_address][8*b +: 8] <= bus.mem_data_in[8*b +: 8];
         end
      end
   end
   typedef struct {
      logic        bd, fr;
      logic [7:0]  fa;
      logic        lr, lw;
      logic [7:0]  la;
      logic [31:0] lwd;
      logic [3:0]  lm;
      logic        fg, lg, frv, lrv, bm;
      logic [31:0] rd;
      logic        crd;
   } vec_t;
   vec_t v [13];
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask
   task automatic cyc(input logic fr, input logic lr, input logic efg, input logic elg);
      @(negedge clk);
      bus.f_req = fr; bus.f_addr = 8'h10; bus.l_req = lr; bus.l_we_re = 1'b0;
      bus.l_addr = 8'h20; bus.l_mask = 4'h0; bus.l_wdata = 32'h0; boot_done = 1'b0;
      #2;
      chk("seq_f_gnt", bus.f_gnt, efg);
      chk("seq_l_gnt", bus.l_gnt, elg);
      chk("seq_mem_request", bus.mem_request, efg | elg);
   endtask
   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0; boot_done = 1'b0;
      bus.f_req = 0; bus.f_addr = 0; bus.l_req = 0; bus.l_we_re = 0;
      bus.l_mask = 0; bus.l_addr = 0; bus.l_wdata = 0;
      //        bd fr fa     lr lw la     lwd            lm    fg lg frv lrv bm rd             crd
      v[0]  = '{0, 1, 8'h10, 1, 1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 1, 0, 0, 1, 32'h0,        0};
      v[1]  = '{0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        4'h0, 0, 0, 0, 1, 1, 32'h0,        0};
      v[2]  = '{0, 1, 8'h20, 1, 1, 8'h20, 32'h12345678, 4'h3, 0, 1, 0, 0, 1, 32'h0,        0};
      v[3]  = '{0, 0, 8'h00, 1, 0, 8'h10, 32'h0,        4'h0, 0, 1, 0, 1, 1, 32'h0,        0};
      v[4]  = '{1, 0, 8'h00, 0, 0, 8'h00, 32'h0,        4'h0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 1};
      v[5]  = '{0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,        0};
      v[6]  = '{0, 1, 8'h10, 0, 0, 8'h00, 32'h0,        4'h0, 1, 0, 0, 0, 0, 32'h0,        0};
      v[7]  = '{0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        4'h0, 0, 0, 1, 0, 0, 32'hDEADBEEF, 1};
      v[8]  = '{0, 1, 8'h20, 0, 0, 8'h00, 32'h0,        4'h0, 1, 0, 0, 0, 0, 32'h0,        0};
      v[9]  = '{0, 0, 8'h00, 1, 0, 8'h10, 32'h0,        4'h0, 0, 1, 1, 0, 0, 32'h00005678, 1};
      v[10] = '{0, 1, 8'h20, 0, 0, 8'h00, 32'h0,        4'h0, 1, 0, 0, 1, 0, 32'hDEADBEEF, 1};
      v[11] = '{0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        4'h0, 0, 0, 1, 0, 0, 32'h00005678, 1};
      v[12] = '{0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,        0};
      @(negedge clk);
      @(negedge clk);
      #2;
      chk("rst_boot_mode", boot_mode, 1'b1);
      chk("rst_f_gnt", bus.f_gnt, 1'b0);
      chk("rst_l_gnt", bus.l_gnt, 1'b0);
      chk("rst_f_rvalid", bus.f_rvalid, 1'b0);
      chk("rst_l_rvalid", bus.l_rvalid, 1'b0);
      chk("rst_mem_request", bus.mem_request, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         boot_done = v[i].bd; bus.f_req = v[i].fr; bus.f_addr = v[i].fa;
         bus.l_req = v[i].lr; bus.l_we_re = v[i].lw; bus.l_addr = v[i].la;
         bus.l_wdata = v[i].lwd; bus.l_mask = v[i].lm;
         #2;
         chk($sformatf("v%0d_f_gnt", i), bus.f_gnt, v[i].fg);
         chk($sformatf("v%0d_l_gnt", i), bus.l_gnt, v[i].lg);
         chk($sformatf("v%0d_f_rvalid", i), bus.f_rvalid, v[i].frv);
         chk($sformatf("v%0d_l_rvalid", i), bus.l_rvalid, v[i].lrv);
         chk($sformatf("v%0d_boot_mode", i), boot_mode, v[i].bm);
         chk($sformatf("v%0d_mem_request", i), bus.mem_request, v[i].fg | v[i].lg);
         chk($sformatf("v%0d_mem_address", i), bus.mem_address, v[i].fg ? v[i].fa : v[i].lg ? v[i].la : 8'h0);
         chk($sformatf("v%0d_mem_we_re", i), bus.mem_we_re, v[i].lg & v[i].lw);
         chk($sformatf("v%0d_mem_mask", i), bus.mem_mask, v[i].fg ? 4'hF : v[i].lg ? v[i].lm : 4'h0);
         chk($sformatf("v%0d_mem_data_in", i), bus.mem_data_in, v[i].lg ? v[i].lwd : 32'h0);
         if (v[i].crd) chk($sformatf("v%0d_rdata", i), v[i].frv ? bus.f_rdata : bus.l_rdata, v[i].rd);
      end
      for (int i = 0; i < 10; i++)
`ifdef IMEM_ARB_RR_EN
         cyc(1'b1, 1'b1, i % 2 == 1, i % 2 == 0);
`else
         cyc(1'b1, 1'b1, i % 5 == 4, i % 5 != 4);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, i == 4, i != 4);
`endif
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b0; bus.f_req = 1'b1; bus.l_req = 1'b1; bus.l_we_re = 1'b1;
      bus.l_mask = 4'hF; bus.l_addr = 8'h33; bus.l_wdata = 32'hCAFEF00D;
      #2;
      chk("mid_rst_f_rvalid", bus.f_rvalid, 1'b0);
      chk("mid_rst_l_rvalid", bus.l_rvalid, 1'b0);
      chk("mid_rst_boot_mode", boot_mode, 1'b1);
      chk("mid_rst_mem_request", bus.mem_request, 1'b0);
      chk("mid_rst_mem_we_re", bus.mem_we_re, 1'b0);
      chk("mid_rst_mem_mask", bus.mem_mask, 4'h0);
      chk("mid_rst_mem_address", bus.mem_address, 8'h0);
      chk("mid_rst_mem_data_in", bus.mem_data_in, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; bus.l_req = 1'b0;
      #2;
      chk("post_rst_f_gnt", bus.f_gnt, 1'b0);
      chk("post_rst_f_rvalid", bus.f_rvalid, 1'b0);
      chk("post_rst_l_rvalid", bus.l_rvalid, 1'b0);
      chk("post_rst_boot_mode", boot_mode, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
